// File: rtl/time_base_pkg.sv
// Shared constants and qualifier state encoding for the frame-timer time base.
package time_base_pkg;

  localparam int CLK_DIV_DEF    = 200;
  localparam int SYNC_MIN_W_DEF = 8;
  localparam int SYNC_TMO_DEF   = 4400;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HIGH     = 2'd1,
    WAIT_LOW = 2'd2
  } qual_state_t;

endpackage

// File: rtl/sync_qualifier.sv
// Synchronises the external frame sync and accepts only pulses that stay high
// for SYNC_MIN_W synchronised clocks; shorter pulses are counted as glitches.
module sync_qualifier
  import time_base_pkg::*;
#(
  parameter int SYNC_MIN_W = SYNC_MIN_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sync_in,
  output logic       accept,
  output logic [7:0] glitch_cnt
);

  localparam logic [7:0] MIN_W = 8'(SYNC_MIN_W);

  logic        sync_meta;
  logic        s_sync;
  qual_state_t state;
  qual_state_t state_next;
  logic [7:0]  wcnt;
  logic [7:0]  wcnt_next;
  logic        accept_next;
  logic        reject;

  // Left unreset so a sync already high during reset is seen as high at
  // release and parks the FSM in WAIT_LOW instead of looking like a new edge.
  always_ff @(posedge clk) begin
    sync_meta <= sync_in;
    s_sync    <= sync_meta;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_LOW;
      wcnt       <= '0;
      accept     <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      state  <= state_next;
      wcnt   <= wcnt_next;
      accept <= accept_next;
      if (reject && (glitch_cnt != 8'hFF)) begin
        glitch_cnt <= glitch_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    state_next  = state;
    wcnt_next   = wcnt;
    accept_next = 1'b0;
    reject      = 1'b0;
    case (state)
      IDLE: begin
        if (s_sync) begin
          wcnt_next = 8'd1;
          // A one-clock minimum width is satisfied on the very first high.
          if (MIN_W == 8'd1) begin
            accept_next = 1'b1;
            state_next  = WAIT_LOW;
          end else begin
            state_next = HIGH;
          end
        end
      end
      HIGH: begin
        if (s_sync) begin
          wcnt_next = wcnt + 8'd1;
          if (wcnt_next == MIN_W) begin
            accept_next = 1'b1;
            state_next  = WAIT_LOW;
          end
        end else begin
          reject     = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT_LOW: begin
        if (!s_sync) begin
          state_next = IDLE;
        end
      end
      default: state_next = WAIT_LOW;
    endcase
  end

endmodule

// File: rtl/time_base_gen.sv
// 5 us tick generator re-phased by qualified frame syncs, with sync counters
// and an optional loss-of-sync watchdog built when SYNC_WATCHDOG_EN is defined.
module time_base_gen
  import time_base_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int SYNC_MIN_W = SYNC_MIN_W_DEF,
  parameter int SYNC_TMO   = SYNC_TMO_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sync_in,
  output logic        t5us,
  output logic        time_clr,
  output logic        sync_lost,
  output logic [15:0] sync_cnt,
  output logic [7:0]  glitch_cnt
);

  localparam logic [15:0] PCNT_LAST = 16'(CLK_DIV - 1);

  logic        accept;
  logic        wrap;
  logic [15:0] pcnt;

  sync_qualifier #(
    .SYNC_MIN_W(SYNC_MIN_W)
  ) u_qual (
    .clk       (clk),
    .reset     (reset),
    .sync_in   (sync_in),
    .accept    (accept),
    .glitch_cnt(glitch_cnt)
  );

  assign wrap = (pcnt == PCNT_LAST);

  // An accepted sync re-phases the prescaler and takes priority over a wrap,
  // so time_clr and t5us never share a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt     <= '0;
      t5us     <= 1'b0;
      time_clr <= 1'b0;
      sync_cnt <= '0;
    end else begin
      time_clr <= accept;
      t5us     <= wrap && !accept;
      if (accept || wrap) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + 16'd1;
      end
      if (accept) begin
        sync_cnt <= sync_cnt + 16'd1;
      end
    end
  end

`ifdef SYNC_WATCHDOG_EN
  localparam logic [15:0] TMO_LIM = 16'(SYNC_TMO);

  logic [15:0] tmo;

  // Counts the same wrap events that produce t5us, so sync_lost rises in
  // the cycle of the tick that reaches the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo       <= '0;
      sync_lost <= 1'b0;
    end else if (accept) begin
      tmo       <= '0;
      sync_lost <= 1'b0;
    end else if (wrap && (tmo != TMO_LIM)) begin
      tmo <= tmo + 16'd1;
      if ((tmo + 16'd1) == TMO_LIM) begin
        sync_lost <= 1'b1;
      end
    end
  end
`else
  // No watchdog in this build; SYNC_TMO is referenced only so both builds
  // share one parameter list, and the expression is constant 0.
  assign sync_lost = 1'b0 & (SYNC_TMO != 0);
`endif

endmodule

// File: tb/tb_time_base_gen.sv
// Randomised bench for time_base_gen checked against a pulse-level reference model.
module tb_time_base_gen;

  localparam int CLK_DIV = 8;
  localparam int MIN_W   = 4;
  localparam int TMO     = 20;
`ifdef SYNC_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sync_in = 1'b0;
  logic        t5us;
  logic        time_clr;
  logic        sync_lost;
  logic [15:0] sync_cnt;
  logic [7:0]  glitch_cnt;

  int total = 0;
  int bad   = 0;

  // reference model state
  int          cyc = 0;
  int          anchor = 0;
  int          ticks = 0;
  int          m_glitch = 0;
  logic [15:0] m_sync_cnt = '0;
  logic        exp_clr = 1'b0;
  logic        exp_t5us = 1'b0;
  logic        exp_lost = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] glitch_q[$];

  // pulse driver mailbox
  int pulse_width = 0;
  int pulse_seq = 0;

  time_base_gen #(
    .CLK_DIV   (CLK_DIV),
    .SYNC_MIN_W(MIN_W),
    .SYNC_TMO  (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sync_in   (sync_in),
    .t5us      (t5us),
    .time_clr  (time_clr),
    .sync_lost (sync_lost),
    .sync_cnt  (sync_cnt),
    .glitch_cnt(glitch_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Reference model: cycle numbers count edges since reset release. Expected
  // clears and rejections are scheduled by the pulse driver; ticks fall on
  // every CLK_DIV-th cycle after the last phase anchor (release or clear).
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        cyc = 0; anchor = 0; ticks = 0; m_glitch = 0; m_sync_cnt = '0;
        exp_clr = 1'b0; exp_t5us = 1'b0; exp_lost = 1'b0;
        exp_q.delete();
        glitch_q.delete();
      end else begin
        cyc++;
        exp_clr = 1'b0;
        if (exp_q.size() > 0 && exp_q[0] == cyc) begin
          void'(exp_q.pop_front());
          exp_clr = 1'b1;
        end
        while (glitch_q.size() > 0 && glitch_q[0] == cyc) begin
          void'(glitch_q.pop_front());
          if (m_glitch < 255) m_glitch++;
        end
        exp_t5us = !exp_clr && ((cyc - anchor) % CLK_DIV == 0);
        if (exp_clr) begin
          anchor = cyc;
          ticks = 0;
          m_sync_cnt = m_sync_cnt + 16'd1;
        end else if (exp_t5us && ticks < TMO) begin
          ticks++;
        end
        exp_lost = WD_EN && (ticks >= TMO);
      end
    end
  end

  // Drives sync_in high for the requested number of sampling edges.
  initial begin
    int last_seq;
    int left;
    last_seq = 0;
    left = 0;
    forever begin
      @(negedge clk);
      #1;
      if (pulse_seq != last_seq) begin
        last_seq = pulse_seq;
        left = pulse_width;
      end
      sync_in = (left > 0);
      if (left > 0) left--;
    end
  end

  // Call just after a negedge; the next posedge is the first to sample high.
  task automatic start_pulse(input int width, input bit track);
    int s;
    s = cyc + 1;
    if (track) begin
      if (width >= MIN_W) exp_q.push_back(32'(s + MIN_W + 2));
      else                glitch_q.push_back(32'(s + width + 2));
    end
    pulse_width = width;
    pulse_seq++;
  endtask

  task automatic test_reset();
    int hits[$];
    int clr_seen;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({t5us, time_clr, sync_lost, sync_cnt, glitch_cnt} !== 27'd0) begin
        bad++;
        $display("FAIL reset_outputs: got=%0h want=0", {t5us, time_clr, sync_lost, sync_cnt, glitch_cnt});
      end
    end
    reset = 1'b0;
    repeat (30) begin
      @(negedge clk);
      total++;
      if (t5us !== exp_t5us) begin
        bad++;
        $display("FAIL first_ticks cyc=%0d: got=%0b want=%0b", cyc, t5us, exp_t5us);
      end
      if (t5us === 1'b1) hits.push_back(cyc);
    end
    total++;
    if (hits.size() != 3 || hits[0] != 8 || hits[1] != 16 || hits[2] != 24) begin
      bad++;
      $display("FAIL tick_cycles: got=%p want=8,16,24", hits);
    end
    // reset in the middle of a qualifying pulse must cancel it completely
    start_pulse(10, 1'b1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      total++;
      if ({t5us, time_clr, sync_lost, sync_cnt, glitch_cnt} !== 27'd0) begin
        bad++;
        $display("FAIL midpulse_reset: got=%0h want=0", {t5us, time_clr, sync_lost, sync_cnt, glitch_cnt});
      end
    end
    reset = 1'b0;
    clr_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (time_clr === 1'b1) clr_seen++;
    end
    total++;
    if (clr_seen != 0 || sync_cnt !== 16'd0) begin
      bad++;
      $display("FAIL midpulse_after: got clr=%0d cnt=%0d want 0,0", clr_seen, sync_cnt);
    end
  endtask

  task automatic test_accept();
    int s;
    int clr_at;
    int clr_seen;
    s = cyc + 1;
    start_pulse(10, 1'b1);
    clr_seen = 0;
    clr_at = -1;
    repeat (20) begin
      @(negedge clk);
      total++;
      if (time_clr !== exp_clr || t5us !== exp_t5us) begin
        bad++;
        $display("FAIL accept_cycle cyc=%0d: got clr=%0b t5=%0b want clr=%0b t5=%0b", cyc, time_clr, t5us, exp_clr, exp_t5us);
      end
      if (time_clr === 1'b1) begin
        clr_seen++;
        clr_at = cyc;
      end
    end
    total++;
    if (clr_seen != 1 || clr_at != s + 6) begin
      bad++;
      $display("FAIL accept_latency: got n=%0d at=%0d want n=1 at=%0d", clr_seen, clr_at, s + 6);
    end
    total++;
    if (sync_cnt !== 16'd1 || glitch_cnt !== 8'd0) begin
      bad++;
      $display("FAIL accept_counts: got sync=%0d glitch=%0d want 1,0", sync_cnt, glitch_cnt);
    end
  endtask

  task automatic test_glitch();
    int clr_seen;
    clr_seen = 0;
    for (int p = 1; p <= 2; p++) begin
      start_pulse(3, 1'b1);
      repeat (10) begin
        @(negedge clk);
        total++;
        if (glitch_cnt !== 8'(m_glitch)) begin
          bad++;
          $display("FAIL glitch_cycle cyc=%0d: got=%0d want=%0d", cyc, glitch_cnt, m_glitch);
        end
        if (time_clr === 1'b1) clr_seen++;
      end
      total++;
      if (glitch_cnt !== 8'(p)) begin
        bad++;
        $display("FAIL glitch_count: got=%0d want=%0d", glitch_cnt, p);
      end
    end
    total++;
    if (clr_seen != 0) begin
      bad++;
      $display("FAIL glitch_no_clr: got=%0d want=0", clr_seen);
    end
  endtask

  task automatic test_watchdog();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (160) begin
      @(negedge clk);
      total++;
      if (sync_lost !== exp_lost || t5us !== exp_t5us) begin
        bad++;
        $display("FAIL wdog_cycle cyc=%0d: got lost=%0b t5=%0b want lost=%0b t5=%0b", cyc, sync_lost, t5us, exp_lost, exp_t5us);
      end
      if (cyc == 159) begin
        total++;
        if (sync_lost !== 1'b0) begin
          bad++;
          $display("FAIL wdog_early: got=%0b want=0", sync_lost);
        end
      end
    end
    total++;
    if (sync_lost !== WD_EN || t5us !== 1'b1) begin
      bad++;
      $display("FAIL wdog_expire: got lost=%0b t5=%0b want lost=%0b t5=1", sync_lost, t5us, WD_EN);
    end
    start_pulse(6, 1'b1);
    repeat (15) begin
      @(negedge clk);
      total++;
      if (sync_lost !== exp_lost || time_clr !== exp_clr) begin
        bad++;
        $display("FAIL wdog_clear cyc=%0d: got lost=%0b clr=%0b want lost=%0b clr=%0b", cyc, sync_lost, time_clr, exp_lost, exp_clr);
      end
      if (time_clr === 1'b1) begin
        total++;
        if (sync_lost !== 1'b0) begin
          bad++;
          $display("FAIL wdog_clr_cycle: got=%0b want=0", sync_lost);
        end
      end
    end
  endtask

  task automatic test_reset_held();
    int clr_seen;
    reset = 1'b1;
    start_pulse(20, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    clr_seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (time_clr === 1'b1) clr_seen++;
    end
    total++;
    if (clr_seen != 0 || glitch_cnt !== 8'd0) begin
      bad++;
      $display("FAIL held_pulse: got clr=%0d glitch=%0d want 0,0", clr_seen, glitch_cnt);
    end
    start_pulse(8, 1'b1);
    clr_seen = 0;
    repeat (15) begin
      @(negedge clk);
      total++;
      if (time_clr !== exp_clr) begin
        bad++;
        $display("FAIL held_next cyc=%0d: got=%0b want=%0b", cyc, time_clr, exp_clr);
      end
      if (time_clr === 1'b1) clr_seen++;
    end
    total++;
    if (clr_seen != 1 || sync_cnt !== 16'd1) begin
      bad++;
      $display("FAIL held_next_count: got clr=%0d cnt=%0d want 1,1", clr_seen, sync_cnt);
    end
  endtask

  task automatic test_coincide();
    int target;
    for (int i = 0; i < CLK_DIV; i++) begin
      if (((cyc + 1 + MIN_W + 2 - anchor) % CLK_DIV) == 0) break;
      @(negedge clk);
    end
    target = cyc + 1 + MIN_W + 2;
    start_pulse(6, 1'b1);
    repeat (20) begin
      @(negedge clk);
      total++;
      if (t5us !== exp_t5us) begin
        bad++;
        $display("FAIL coincide_tick cyc=%0d: got=%0b want=%0b", cyc, t5us, exp_t5us);
      end
      if (cyc == target) begin
        total++;
        if (time_clr !== 1'b1 || t5us !== 1'b0) begin
          bad++;
          $display("FAIL coincide_clr: got clr=%0b t5=%0b want clr=1 t5=0", time_clr, t5us);
        end
      end
      if (cyc == target + CLK_DIV) begin
        total++;
        if (t5us !== 1'b1) begin
          bad++;
          $display("FAIL coincide_next: got=%0b want=1", t5us);
        end
      end
    end
  endtask

  task automatic test_random();
    int w;
    int gap;
    repeat (40) begin
      w = $urandom_range(1, 10);
      gap = $urandom_range(2, 8);
      start_pulse(w, 1'b1);
      repeat (w + gap) begin
        @(negedge clk);
        total++;
        if (t5us !== exp_t5us || time_clr !== exp_clr || sync_lost !== exp_lost ||
            sync_cnt !== m_sync_cnt || glitch_cnt !== 8'(m_glitch)) begin
          bad++;
          $display("FAIL random cyc=%0d: got t5=%0b clr=%0b lost=%0b sc=%0d gc=%0d want t5=%0b clr=%0b lost=%0b sc=%0d gc=%0d",
                   cyc, t5us, time_clr, sync_lost, sync_cnt, glitch_cnt,
                   exp_t5us, exp_clr, exp_lost, m_sync_cnt, m_glitch);
        end
      end
    end
  endtask

  task automatic test_glitch_saturate();
    int w;
    repeat (260) begin
      w = $urandom_range(1, MIN_W - 1);
      start_pulse(w, 1'b1);
      repeat (w + 2) begin
        @(negedge clk);
        total++;
        if (glitch_cnt !== 8'(m_glitch) || time_clr !== exp_clr) begin
          bad++;
          $display("FAIL glitch_sat cyc=%0d: got gc=%0d clr=%0b want gc=%0d clr=%0b", cyc, glitch_cnt, time_clr, m_glitch, exp_clr);
        end
      end
    end
    repeat (4) @(negedge clk);
    total++;
    if (glitch_cnt !== 8'd255) begin
      bad++;
      $display("FAIL glitch_saturated: got=%0d want=255", glitch_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_glitch();
    test_watchdog();
    test_reset_held();
    test_coincide();
    test_random();
    test_glitch_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
